// File: rtl/imem_loader.sv
// Framed byte-stream loader for the CPU instruction memory: count, data words, checksum.
// Holds the CPU (cpu_hold) until a load finishes with a matching checksum.
module imem_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [9:0]        words_loaded,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
  // depends only on the registered state, never on in_valid.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state, state_nx;
  logic [7:0]  cnt_hi;
  logic [15:0] count;
  logic [7:0]  hi_byte;
  logic [7:0]  sum;
  logic        xfer;
  logic        start_load;
  logic [15:0] count_n;
  logic        count_ok;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign count_n   = {cnt_hi, in_data};
  assign count_ok  = (count_n != 16'd0) && (count_n <= DEPTH_W);
  assign last_word = (16'(words_loaded) + 16'd1) == count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    start_load = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_nx   = CNT_HI;
          start_load = 1'b1;
        end
      end
      CNT_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = count_ok ? DATA_HI : ERROR;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = last_word ? CHECK : DATA_HI;
      end
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = (in_data == sum) ? DONE : ERROR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_hi       <= 8'd0;
      count        <= 16'd0;
      hi_byte      <= 8'd0;
      sum          <= 8'd0;
      words_loaded <= 10'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      if (start_load) begin
        sum          <= 8'd0;
        words_loaded <= 10'd0;
      end else if (xfer) begin
        case (state)
          CNT_HI: cnt_hi <= in_data;
          CNT_LO: count  <= count_n;
          DATA_HI: begin
            hi_byte <= in_data;
            sum     <= sum + in_data;
          end
          DATA_LO: begin
            mem_we       <= 1'b1;
            mem_addr     <= ADDR_W'(words_loaded);
            mem_wdata    <= {hi_byte, in_data};
            sum          <= sum + in_data;
            words_loaded <= words_loaded + 10'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Single-state decodes keep cpu_hold free of a low pulse except on DONE entry.
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_hold  = (state != IDLE) && (state != DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames built from a word list, expected writes and
// outcome derived from the frame rules, random data and random stalls.
module tb_imem_loader;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy, done, error, cpu_hold;
  logic [9:0]        words_loaded;
  logic [2:0]        dbg_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
    .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [25:0] exp_q[$];   // {addr[9:0], data[15:0]}
  logic [15:0] word_q[$];
  logic [7:0]  byte_q[$];
  logic        exp_done, exp_error;
  logic [9:0]  exp_words;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) chk("spurious_we", 32'd1, 32'd0);
      else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        chk("we_addr", 32'(mem_addr), 32'(e[25:16]));
        chk("we_data", 32'(mem_wdata), 32'(e[15:0]));
      end
    end
  end

  // Reference model: frame from word_q, expected writes/outcome from the frame rules.
  task automatic build_frame(input logic [15:0] n_field, input logic [7:0] ck_offset);
    logic [7:0] s;
    byte_q.delete();
    byte_q.push_back(n_field[15:8]);
    byte_q.push_back(n_field[7:0]);
    if (n_field == 0 || n_field > DEPTH) begin
      exp_done = 1'b0; exp_error = 1'b1; exp_words = 10'd0;
      return;
    end
    s = 8'd0;
    for (int k = 0; k < int'(n_field); k++) begin
      byte_q.push_back(word_q[k][15:8]);
      byte_q.push_back(word_q[k][7:0]);
      s = s + word_q[k][15:8] + word_q[k][7:0];
      exp_q.push_back({10'(k), word_q[k]});
    end
    byte_q.push_back(s + ck_offset);
    exp_done  = (ck_offset == 8'd0);
    exp_error = (ck_offset != 8'd0);
    exp_words = 10'(n_field);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // drive byte_q[first..last]; throttle toggles in_valid and adds random stalls
  task automatic send_bytes(input int first, input int last, input bit throttle, output int cyc);
    int guard;
    cyc = 0;
    for (int i = first; i <= last; i++) begin
      if (throttle) begin
        in_valid = 1'b0;
        repeat ((i % 2) + $urandom_range(0, 2)) begin @(negedge clk); cyc++; end
      end
      in_valid = 1'b1;
      in_data  = byte_q[i];
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; cyc++; end
      if (!in_ready) begin
        chk("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_outcome(input string tag);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(exp_error));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(exp_error));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic nominal_words();
    word_q.delete();
    word_q.push_back(16'h7100);
    word_q.push_back(16'h5105);
    word_q.push_back(16'hF000);
  endtask

  initial begin
    int cyc;
    int n;
    logic [15:0] base;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // stream bytes offered before any start are not consumed
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (4) begin @(negedge clk); chk("idle_ready", 32'(in_ready), 32'd0); end
    chk("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // nominal frame 00 03 71 00 51 05 F0 00 B7, back-to-back
    nominal_words();
    build_frame(16'd3, 8'd0);
    chk("nominal_checksum_byte", 32'(byte_q[8]), 32'hB7);
    do_start();
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hold", 32'(cpu_hold), 32'd1);
    send_bytes(0, 8, 1'b0, cyc);
    chk("nominal_cycles", 32'(cyc), 32'd9);
    check_outcome("nominal");

    // bytes after DONE are not consumed
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin @(negedge clk); chk("after_done_ready", 32'(in_ready), 32'd0); end
    in_valid = 1'b0;
    chk("after_done_still_done", 32'(done), 32'd1);

    // bad checksum B6: writes still happen, then error
    nominal_words();
    build_frame(16'd3, 8'hFF);
    chk("bad_checksum_byte", 32'(byte_q[8]), 32'hB6);
    do_start();
    chk("restart_clears_done", 32'(done), 32'd0);
    send_bytes(0, 8, 1'b0, cyc);
    check_outcome("bad_ck");

    // correct reload recovers
    nominal_words();
    build_frame(16'd3, 8'd0);
    do_start();
    send_bytes(0, 8, 1'b1, cyc);
    check_outcome("reload");

    // illegal counts: 0 and DEPTH+1
    word_q.delete();
    build_frame(16'h0000, 8'd0);
    do_start();
    send_bytes(0, 1, 1'b0, cyc);
    check_outcome("count_zero");
    build_frame(16'h0201, 8'd0);
    do_start();
    send_bytes(0, 1, 1'b1, cyc);
    check_outcome("count_over");
    in_valid = 1'b1; in_data = 8'h12;
    repeat (3) @(negedge clk);
    chk("error_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // random short loads with random stalls
    repeat (4) begin
      n = $urandom_range(1, 20);
      word_q.delete();
      for (int k = 0; k < n; k++) word_q.push_back(16'($urandom));
      build_frame(16'(n), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0);
      do_start();
      send_bytes(0, byte_q.size() - 1, 1'b1, cyc);
      check_outcome("random");
    end

    // full-depth ramp, throttled
    base = 16'($urandom);
    word_q.delete();
    for (int k = 0; k < DEPTH; k++) word_q.push_back(base + 16'(k));
    build_frame(16'(DEPTH), 8'd0);
    do_start();
    send_bytes(0, byte_q.size() - 1, 1'b1, cyc);
    check_outcome("ramp512");
    chk("ramp512_last_addr", 32'(mem_addr), 32'(DEPTH - 1));

    // start pulsed mid-load is ignored
    nominal_words();
    build_frame(16'd3, 8'd0);
    do_start();
    send_bytes(0, 3, 1'b0, cyc);
    do_start();
    chk("mid_start_busy", 32'(busy), 32'd1);
    send_bytes(4, 8, 1'b0, cyc);
    check_outcome("mid_start");

    // reset after 5 of 9 bytes: one write done, two never happen
    nominal_words();
    build_frame(16'd3, 8'd0);
    do_start();
    send_bytes(0, 4, 1'b0, cyc);
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    chk("mid_reset_unwritten", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", 32'(dbg_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
